// File: rtl/tx_frame_queue_pkg.sv
// Shared definitions for the transmit frame queue: frame width, default
// queue sizing and the encoder-pacing FSM state encodings.
package tx_frame_queue_pkg;

    localparam int FRAME_SIZE     = 16;
    localparam int TXQ_DEPTH      = 4;
    localparam int TXQ_GAP_CYCLES = 2;

    typedef enum logic [1:0] {
        TXQ_IDLE = 2'd0,
        TXQ_SEND = 2'd1,
        TXQ_GAP  = 2'd2
    } txq_state_e;

endpackage

// File: rtl/tx_frame_queue_frame_fifo.sv
// Circular frame store with registered occupancy; a push while full is
// dropped and flagged by a one-cycle overflow pulse.
module frame_fifo
    import tx_frame_queue_pkg::*;
#(
    parameter int WIDTH = FRAME_SIZE,
    parameter int DEPTH = TXQ_DEPTH,
    localparam int PW   = $clog2(DEPTH),
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [LW-1:0]    o_level,
    output logic             o_overflow
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             r_overflow;
    logic             w_full;
    logic             w_do_push;

    // Fullness comes from the registered level, so a same-cycle pop never
    // frees a slot for the incoming write.
    assign w_full    = (r_level == LW'(DEPTH));
    assign w_do_push = i_push && !w_full;

    always_ff @(posedge clock) begin
        if (w_do_push)
            r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= i_push && w_full;
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (i_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_do_push, i_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_head     = r_mem[r_rd_ptr];
    assign o_full     = w_full;
    assign o_empty    = (r_level == '0);
    assign o_level    = r_level;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/tx_frame_queue.sv
// Host-side transmit queue: buffers frames and feeds them to the encoder one
// at a time, holding start low for an idle gap after each completion.
module tx_frame_queue #(
    parameter int FRAME_SIZE = tx_frame_queue_pkg::FRAME_SIZE,
    parameter int DEPTH      = tx_frame_queue_pkg::TXQ_DEPTH,
    parameter int GAP_CYCLES = tx_frame_queue_pkg::TXQ_GAP_CYCLES,
    localparam int LW        = $clog2(DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [FRAME_SIZE-1:0] wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [LW-1:0]         level,
    output logic                  overflow,
    output logic [FRAME_SIZE-1:0] enc_data,
    output logic                  enc_start,
    input  logic                  enc_irq,
    output logic                  sent
);
    import tx_frame_queue_pkg::*;

    localparam int CW = $clog2(GAP_CYCLES + 1);

    txq_state_e            r_state;
    logic [CW-1:0]         r_gap_cnt;
    logic [FRAME_SIZE-1:0] r_enc_data;
    logic                  r_enc_start;
    logic                  r_sent;
    logic [FRAME_SIZE-1:0] w_head;
    logic                  w_empty;
    logic                  w_pop;

    assign w_pop = (r_state == TXQ_IDLE) && !w_empty;

    frame_fifo #(
        .WIDTH (FRAME_SIZE),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .i_push     (wr_en),
        .i_data     (wr_data),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_full     (full),
        .o_empty    (w_empty),
        .o_level    (level),
        .o_overflow (overflow)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= TXQ_IDLE;
            r_gap_cnt   <= '0;
            r_enc_data  <= '0;
            r_enc_start <= 1'b0;
            r_sent      <= 1'b0;
        end else begin
            r_sent <= 1'b0;
            case (r_state)
                TXQ_IDLE: begin
                    if (!w_empty) begin
                        r_enc_data  <= w_head;
                        r_enc_start <= 1'b1;
                        r_state     <= TXQ_SEND;
                    end
                end
                TXQ_SEND: begin
                    if (enc_irq) begin
                        r_enc_start <= 1'b0;
                        r_sent      <= 1'b1;
                        r_gap_cnt   <= CW'(GAP_CYCLES - 1);
                        r_state     <= TXQ_GAP;
                    end
                end
                TXQ_GAP: begin
                    // A lingering irq would look like completion of the next
                    // frame, so wait for it to drop before restarting.
                    if (r_gap_cnt != '0)
                        r_gap_cnt <= r_gap_cnt - CW'(1);
                    else if (!enc_irq)
                        r_state <= TXQ_IDLE;
                end
                default: r_state <= TXQ_IDLE;
            endcase
        end
    end

    assign empty     = w_empty;
    assign enc_data  = r_enc_data;
    assign enc_start = r_enc_start;
    assign sent      = r_sent;

endmodule

// File: tb/tb_tx_frame_queue.sv
// Directed bench for tx_frame_queue with a behavioural encoder that raises
// irq a programmable number of cycles after start and logs each frame.
module tb_tx_frame_queue;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic [15:0] wr_data = '0;
    logic        full, empty, overflow, enc_start, sent;
    logic [2:0]  level;
    logic [15:0] enc_data;
    logic        enc_irq = 1'b0;

    int total = 0, bad = 0;
    int enc_lat = 3, irq_hold = 1;
    int n_rx = 0, n_start = 0, sent_cnt = 0, unstable = 0;
    int gap_last = 0, low_run = 0, busy_cnt = 0, hold_left = 0;
    logic [15:0] rx [0:63];
    logic [15:0] start_data = '0;
    logic        prev_start = 1'b0;

    always #5 clock = ~clock;

    tx_frame_queue #(.FRAME_SIZE(16), .DEPTH(4), .GAP_CYCLES(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .overflow  (overflow),
        .enc_data  (enc_data),
        .enc_start (enc_start),
        .enc_irq   (enc_irq),
        .sent      (sent)
    );

    // Encoder stand-in, evaluated mid-cycle away from the DUT's edge.
    always @(negedge clock) begin
        if (sent) sent_cnt++;
        if (!reset) begin
            enc_irq    = 1'b0;
            busy_cnt   = 0;
            hold_left  = 0;
            prev_start = 1'b0;
        end else begin
            if (enc_start && !prev_start) begin
                n_start++;
                gap_last   = low_run;
                start_data = enc_data;
            end
            if (!enc_start) low_run++;
            else low_run = 0;
            prev_start = enc_start;
            if (enc_start && enc_data !== start_data) unstable++;
            if (hold_left > 0) begin
                hold_left--;
                if (hold_left == 0) enc_irq = 1'b0;
            end else if (enc_start) begin
                busy_cnt++;
                if (busy_cnt >= enc_lat) begin
                    enc_irq   = 1'b1;
                    hold_left = irq_hold;
                    busy_cnt  = 0;
                    if (n_rx < 64) rx[n_rx] = enc_data;
                    n_rx++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write(input logic [15:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic wait_sent(input int target, input string tag);
        int k = 0;
        while (sent_cnt < target && k < 500) begin
            step();
            k++;
        end
        chk(tag, sent_cnt, target);
    endtask

    task automatic wait_irq(input string tag);
        int k = 0;
        while (!enc_irq && k < 200) begin
            step();
            k++;
        end
        chk(tag, {31'd0, enc_irq}, 1);
    endtask

    initial begin
        int ns, nr;
        // Reset state
        step(); step();
        chk("rst_start", enc_start, 0);
        chk("rst_data", enc_data, 16'h0000);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_level", level, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_sent", sent, 0);
        reset = 1'b1;
        step();

        // Single frame and its latency
        write(16'hF4B6);
        chk("s1_level", level, 1);
        chk("s1_empty", empty, 0);
        chk("s1_start_early", enc_start, 0);
        step();
        chk("s1_start", enc_start, 1);
        chk("s1_data", enc_data, 16'hF4B6);
        chk("s1_level_pop", level, 0);
        wait_irq("s1_irq_seen");
        chk("s1_sent", sent, 1);
        chk("s1_start_fall", enc_start, 0);
        chk("s1_data_kept", enc_data, 16'hF4B6);
        step();
        chk("s1_sent_pulse", sent, 0);
        wait_sent(1, "s1_sent_cnt");
        chk("s1_rx", rx[0], 16'hF4B6);
        chk("s1_nrx", n_rx, 1);
        chk("s1_empty_end", empty, 1);

        // Back-to-back frames, minimum idle gap
        repeat (5) step();
        write(16'hF4B6);
        write(16'h4FF4);
        wait_sent(3, "b2b_sent");
        chk("b2b_rx0", rx[1], 16'hF4B6);
        chk("b2b_rx1", rx[2], 16'h4FF4);
        chk("b2b_gap", gap_last, 3);

        // irq held high stretches the gap
        repeat (5) step();
        irq_hold = 3;
        write(16'h1111);
        write(16'h2222);
        wait_sent(5, "hold_sent");
        chk("hold_gap", gap_last, 4);
        chk("hold_rx", rx[4], 16'h2222);
        irq_hold = 1;

        // Full / overflow while encoder is busy
        repeat (6) step();
        enc_lat = 40;
        write(16'hB000);
        step();
        chk("ovf_busy", enc_start, 1);
        write(16'hA001); chk("ovf_lvl1", level, 1);
        write(16'hA002); chk("ovf_lvl2", level, 2);
        write(16'hA003); chk("ovf_lvl3", level, 3);
        chk("ovf_notfull", full, 0);
        write(16'hA004); chk("ovf_lvl4", level, 4);
        chk("ovf_full", full, 1);
        write(16'hA005);
        chk("ovf_pulse", overflow, 1);
        chk("ovf_lvl_hold", level, 4);
        step();
        chk("ovf_pulse_end", overflow, 0);
        enc_lat = 3;
        wait_sent(10, "ovf_sent");
        repeat (20) step();
        chk("ovf_nrx", n_rx, 10);
        chk("ovf_rx_b", rx[5], 16'hB000);
        for (int i = 0; i < 4; i++) chk("ovf_rx", rx[6+i], 32'hA001 + i);
        chk("ovf_empty", empty, 1);

        // Wrap-around: 10 frames in bursts of 3
        for (int i = 0; i < 10; i++) begin
            write(16'hC000 + 16'(i));
            if (i % 3 == 2 || i == 9) wait_sent(11 + i, "wrap_sent");
        end
        for (int i = 0; i < 10; i++) chk("wrap_rx", rx[10+i], 32'hC000 + i);
        repeat (6) step();
        chk("wrap_level", level, 0);
        chk("wrap_empty", empty, 1);

        // Write on the same edge as a pop with level==1
        write(16'hD001);
        chk("sim_lvl_pre", level, 1);
        write(16'hD002);
        chk("sim_lvl", level, 1);
        chk("sim_start", enc_start, 1);
        chk("sim_data", enc_data, 16'hD001);
        wait_sent(22, "sim_sent");
        chk("sim_rx0", rx[20], 16'hD001);
        chk("sim_rx1", rx[21], 16'hD002);

        // Reset mid-frame with two queued
        repeat (6) step();
        enc_lat = 40;
        write(16'hE001);
        write(16'hE002);
        write(16'hE003);
        step(); step();
        chk("mid_start", enc_start, 1);
        chk("mid_level", level, 2);
        reset = 1'b0;
        #1;
        chk("mid_rst_start", enc_start, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_data", enc_data, 16'h0000);
        step(); step();
        reset = 1'b1;
        ns = n_start;
        nr = n_rx;
        repeat (20) step();
        chk("mid_no_start", n_start, ns);
        chk("mid_no_rx", n_rx, nr);
        chk("mid_idle", enc_start, 0);
        enc_lat = 3;
        write(16'hE00F);
        wait_sent(23, "mid_new_sent");
        chk("mid_new_rx", rx[nr], 16'hE00F);

        chk("data_stable", unstable, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tx_frame_queue.md
# tx_frame_queue

Transmit-side frame buffer between the host and the `encoder`. Accepts `FRAME_SIZE`-bit frames from the host on a write strobe and stores them in a small circular FIFO. Presents each frame to the encoder on `data`/`start`, and uses the encoder's `irq` to pace frames back-to-back with an enforced idle gap. The host can therefore queue several frames without polling the encoder handshake.

## Interface
Parameters:
- `FRAME_SIZE`, `` `FRAME_SIZE `` (16), frame width; must match encoder/decoder.
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `GAP_CYCLES`, 2, minimum cycles `enc_start` stays low between frames; ≥1.

Ports:
- `clock`  in  1  single system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  host write strobe; one frame per high cycle.
- `wr_data`  in  FRAME_SIZE  frame to queue.
- `full`  out  1  FIFO holds DEPTH entries.
- `empty`  out  1  FIFO holds 0 entries.
- `level`  out  $clog2(DEPTH+1)  current entry count.
- `overflow`  out  1  one-cycle pulse: write dropped because full.
- `enc_data`  out  FRAME_SIZE  to encoder `data`; stable while `enc_start`=1.
- `enc_start`  out  1  to encoder `start`; level, held high for the whole frame.
- `enc_irq`  in  1  from encoder `irq`; high = frame fully transmitted.
- `sent`  out  1  one-cycle pulse per completed frame.

## Operation
- FIFO: DEPTH × FRAME_SIZE registers.
  - Read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - Occupancy is tracked in `level`; `full` = (level==DEPTH); `empty` = (level==0).
- Write: `wr_en` && !`full` stores `wr_data` at the write pointer and increments the pointer.
- `wr_en` && `full`: data is dropped, `overflow` pulses, and no state changes. `full` is the registered value; a same-cycle pop does not make room.
- Simultaneous write and pop: both occur and `level` is unchanged. Pop from empty never happens.
- FSM states: IDLE, SEND, GAP.
  - IDLE: if !`empty`, pop the head into `enc_data`, set `enc_start`<=1, go to SEND. Otherwise stay.
  - SEND: hold `enc_data` and `enc_start`. When `enc_irq` is sampled 1: `enc_start`<=0, `sent`<=1 for one cycle, gap counter <= GAP_CYCLES-1, go to GAP.
  - GAP: decrement the counter to 0. Go to IDLE when counter==0 and `enc_irq`==0. If `enc_irq` stays high, remain in GAP.
- `enc_data` keeps the last frame after completion; it is not cleared.
- Reset (async, `reset`=0), regardless of state:
  - `enc_start`=0, `enc_data`=0, pointers and `level`=0.
  - `empty`=1, `full`=0, `overflow`=0, `sent`=0, state IDLE.
  - A frame in flight is aborted and queued frames are discarded.

## Timing
- Write to empty FIFO at edge N: `level`=1 after N. Frame popped at N+1. `enc_start`=1 and `enc_data` valid from N+2.
- `enc_irq` sampled high at edge M: `enc_start`=0 and `sent`=1 during M+1.
- Next frame: `enc_start` re-rises no earlier than edge M+GAP_CYCLES+1, i.e. ≥GAP_CYCLES low cycles.
- Status outputs (`full`, `empty`, `level`) are registered and update the cycle after a write or pop.
- `overflow` and `sent` are registered one-cycle pulses.
- No combinational path from any input to any output.

## Structure
- `FRAME_SIZE` stays in `definitions.v`.
- Add FSM state encodings and the default `DEPTH`/`GAP_CYCLES` to the shared definitions (`TXQ_IDLE`, `TXQ_SEND`, `TXQ_GAP`).
- One sub-module: `frame_fifo` (storage, pointers, `level`/`full`/`empty`/`overflow`, push/pop ports).
- `tx_frame_queue` holds the FSM and gap counter and instantiates `frame_fifo`.

## Test plan
Bench: `tx_frame_queue` → `encoder` → `decoder` loop, 2-unit clock.
- Single frame: write 16'hF4B6 → `enc_start` high two cycles later. Decoder `irq` with `data`=16'hF4B6, one `sent` pulse, `empty`=1.
- Back-to-back: write 16'hF4B6, 16'h4FF4 on consecutive cycles → decoder receives both in order. `enc_start` low ≥2 cycles between them.
- Full/overflow: with the encoder busy, write 5 frames → `full`=1 after 4, `overflow` pulses on the 5th. The first 4 frames arrive intact; the 5th never does.
- Wrap-around: queue and send 10 distinct frames in bursts of 3 → all received in order, pointers wrap, `level` returns to 0.
- Simultaneous write/pop: write on the same edge the FSM pops with `level`=1 → `level` stays 1 and no frame is lost.
- Reset mid-frame: assert `reset`=0 while `enc_start`=1 with 2 queued → `enc_start`=0 immediately, `empty`=1. After release, no frame is sent until a new write.
